// File: rtl/morse_pattern_receiver_if.sv
// Signal bundle between a keyed-input source and the Morse receiver.
// SYM_VALID, ERROR and WORD_GAP are single-cycle strobes with no back-pressure; SYM_BITS/SYM_LEN stay valid until the next SYM_VALID.
interface morse_pattern_receiver_if #(
  parameter int MAX_ELEMS = 6
);
  localparam int LEN_W = $clog2(MAX_ELEMS + 1);

  logic                 SIG;
  logic                 SYM_VALID;
  logic [MAX_ELEMS-1:0] SYM_BITS;
  logic [LEN_W-1:0]     SYM_LEN;
  logic                 WORD_GAP;
  logic                 ERROR;
  logic                 ACTIVE;
  logic [1:0]           dbg_state;

  modport master (
    output SIG,
    input  SYM_VALID, SYM_BITS, SYM_LEN, WORD_GAP, ERROR, ACTIVE, dbg_state
  );

  modport slave (
    input  SIG,
    output SYM_VALID, SYM_BITS, SYM_LEN, WORD_GAP, ERROR, ACTIVE, dbg_state
  );
endinterface

// File: rtl/morse_pattern_receiver.sv
// Morse receiver: synchronises an on/off keyed line, classifies marks into dots/dashes
// by unit length, and emits one symbol per character plus word-gap strobes.
module morse_pattern_receiver #(
  parameter int TICK_RATE      = 5_000_000,
  parameter int MAX_ELEMS      = 6,
  parameter int CHAR_GAP_UNITS = 2,
  parameter int WORD_GAP_UNITS = 5
) (
  input logic                     CLK,
  input logic                     RESETN,
  morse_pattern_receiver_if.slave bus
);
  localparam int LEN_W = $clog2(MAX_ELEMS + 1);
  localparam int ECW   = $clog2(MAX_ELEMS + 2);

  localparam logic [31:0]    CHAR_TH  = 32'(CHAR_GAP_UNITS * TICK_RATE);
  localparam logic [31:0]    WORD_TH  = 32'(WORD_GAP_UNITS * TICK_RATE);
  localparam logic [32:0]    DOT_MIN  = 33'(TICK_RATE - TICK_RATE / 2);
  localparam logic [32:0]    DASH_MIN = 33'(3 * TICK_RATE - TICK_RATE / 2);
  localparam logic [ECW-1:0] MAX_CNT  = ECW'(MAX_ELEMS);

  typedef enum logic [1:0] {IDLE, MARK, SPACE, GAP_WAIT} state_t;

  state_t               state, state_next;
  logic                 sig_m, sig_s, sig_d;
  logic [31:0]          cnt;
  logic [ECW-1:0]       elem_cnt;
  logic [MAX_ELEMS-1:0] shreg;
  logic                 sym_valid, err, word_gap;
  logic [MAX_ELEMS-1:0] sym_bits;
  logic [LEN_W-1:0]     sym_len;
  logic                 rise, fall, glitch, dash;
  logic [32:0]          mark_len;
  logic                 active, do_emit, do_word, do_append;

  assign rise     = sig_s & ~sig_d;
  assign fall     = ~sig_s & sig_d;
  // cnt restarts the cycle after an edge is seen, so the closing edge sees length-1
  assign mark_len = {1'b0, cnt} + 33'd1;
  assign glitch   = mark_len < DOT_MIN;
  assign dash     = mark_len >= DASH_MIN;

  always_ff @(posedge CLK) begin
    if (!RESETN) state <= IDLE;
    else         state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:     if (rise) state_next = MARK;
      MARK:     if (fall) state_next = (glitch && elem_cnt == '0) ? IDLE : SPACE;
      SPACE: begin
        if (cnt == CHAR_TH) state_next = rise ? MARK : GAP_WAIT;
        else if (rise)      state_next = MARK;
      end
      GAP_WAIT: begin
        if (cnt == WORD_TH) state_next = rise ? MARK : IDLE;
        else if (rise)      state_next = MARK;
      end
      default:  state_next = IDLE;
    endcase
  end

  always_comb begin
    active    = 1'b0;
    do_emit   = 1'b0;
    do_word   = 1'b0;
    do_append = 1'b0;
    case (state)
      MARK: begin
        active    = 1'b1;
        do_append = fall && !glitch;
      end
      SPACE: begin
        active  = 1'b1;
        do_emit = (cnt == CHAR_TH);
      end
      GAP_WAIT: do_word = (cnt == WORD_TH);
      default: ;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RESETN) begin
      sig_m     <= 1'b0;
      sig_s     <= 1'b0;
      sig_d     <= 1'b0;
      cnt       <= '0;
      elem_cnt  <= '0;
      shreg     <= '0;
      sym_valid <= 1'b0;
      err       <= 1'b0;
      word_gap  <= 1'b0;
      sym_bits  <= '0;
      sym_len   <= '0;
    end else begin
      sig_m     <= bus.SIG;
      sig_s     <= sig_m;
      sig_d     <= sig_s;
      if (rise || fall)   cnt <= '0;
      else if (cnt != '1) cnt <= cnt + 32'd1;
      sym_valid <= 1'b0;
      err       <= 1'b0;
      word_gap  <= do_word;
      if (do_emit) begin
        elem_cnt <= '0;
        shreg    <= '0;
        if (elem_cnt <= MAX_CNT) begin
          sym_bits  <= shreg;
          sym_len   <= LEN_W'(elem_cnt);
          sym_valid <= 1'b1;
        end else begin
          err <= 1'b1;
        end
      end else if (do_append) begin
        // a count of MAX_ELEMS+1 marks the symbol as overflowed
        if (elem_cnt < MAX_CNT)  shreg[elem_cnt] <= dash;
        if (elem_cnt <= MAX_CNT) elem_cnt <= elem_cnt + ECW'(1);
      end
    end
  end

  assign bus.SYM_VALID = sym_valid;
  assign bus.SYM_BITS  = sym_bits;
  assign bus.SYM_LEN   = sym_len;
  assign bus.WORD_GAP  = word_gap;
  assign bus.ERROR     = err;
  assign bus.ACTIVE    = active;
  assign bus.dbg_state = state;
endmodule

// File: tb/tb_morse_pattern_receiver.sv
// Bench for morse_pattern_receiver: drives keyed line segments, predicts symbols from unit arithmetic.
module tb_morse_pattern_receiver;
  localparam int T       = 8;
  localparam int MAXE    = 6;
  localparam int CHAR_TH = 2 * T;
  localparam int WORD_TH = 5 * T;
  localparam int W       = 43;
  localparam logic [1:0] K_VALID = 2'd1;
  localparam logic [1:0] K_ERROR = 2'd2;
  localparam logic [1:0] K_WORD  = 2'd3;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  int   cyc  = 0;
  int   errors = 0;
  int   checks = 0;

  morse_pattern_receiver_if #(.MAX_ELEMS(MAXE)) bus ();

  morse_pattern_receiver #(
    .TICK_RATE(T), .MAX_ELEMS(MAXE), .CHAR_GAP_UNITS(2), .WORD_GAP_UNITS(5)
  ) dut (
    .CLK(clk), .RESETN(rstn), .bus(bus)
  );

  // ---------------- clock / cycle count ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- model state / scoreboard ----------------
  // entry: {kind[2], len[3], bits[6], due_cycle[32]}
  logic [W-1:0]    exp_q[$];
  int              held_n = 0;
  logic [MAXE-1:0] held_bits = '0;
  logic [MAXE-1:0] cur_bits = '0;
  logic [2:0]      cur_len = '0;
  int n_valid = 0, n_error = 0, n_word = 0;
  int last_valid_cyc = 0, last_word_cyc = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // ---------------- driver tasks ----------------
  // A line segment of n cycles. Marks round to units; a space of S cycles closes the
  // symbol when S-1 reaches the char threshold (two sync flops, counter restart, registered strobe).
  task automatic seg(input bit lvl, input int n);
    int start;
    int units;
    start   = cyc;
    bus.SIG = lvl;
    if (lvl) begin
      units = (n + T / 2) / T;
      if (units > 0) begin
        if (held_n < MAXE) held_bits[held_n] = (units >= 3);
        if (held_n <= MAXE) held_n++;
      end
    end else if (held_n > 0 && n >= CHAR_TH + 1) begin
      if (held_n <= MAXE)
        exp_q.push_back({K_VALID, 3'(held_n), held_bits, 32'(start + CHAR_TH + 4)});
      else
        exp_q.push_back({K_ERROR, 3'd0, 6'd0, 32'(start + CHAR_TH + 4)});
      held_n    = 0;
      held_bits = '0;
      if (n >= WORD_TH + 1)
        exp_q.push_back({K_WORD, 3'd0, 6'd0, 32'(start + WORD_TH + 4)});
    end
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    @(posedge clk);
    #1;
    rstn      = 1'b1;
    held_n    = 0;
    held_bits = '0;
    cur_bits  = '0;
    cur_len   = '0;
    exp_q.delete();
  endtask

  task automatic expect_pulse(input logic [1:0] kind);
    logic [W-1:0] e;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL unexpected_pulse: kind %0d at cycle %0d, expected none", kind, cyc);
      return;
    end
    e = exp_q.pop_front();
    check("event_kind", 32'(kind), 32'(e[42:41]));
    check("event_cycle", 32'(cyc), e[31:0]);
    if (e[42:41] == K_VALID) begin
      cur_len  = e[40:38];
      cur_bits = e[37:32];
    end
    if (kind == K_VALID) begin n_valid++; last_valid_cyc = cyc; end
    if (kind == K_ERROR) n_error++;
    if (kind == K_WORD)  begin n_word++; last_word_cyc = cyc; end
  endtask

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    if (rstn) begin
      while (exp_q.size() > 0 && int'(exp_q[0][31:0]) < cyc) begin
        checks++;
        errors++;
        $display("FAIL missed_event: kind %0d due cycle %0d, not seen by cycle %0d",
                 exp_q[0][42:41], exp_q[0][31:0], cyc);
        if (exp_q[0][42:41] == K_VALID) begin
          cur_len  = exp_q[0][40:38];
          cur_bits = exp_q[0][37:32];
        end
        void'(exp_q.pop_front());
      end
      if (bus.SYM_VALID) expect_pulse(K_VALID);
      if (bus.ERROR)     expect_pulse(K_ERROR);
      if (bus.WORD_GAP)  expect_pulse(K_WORD);
      check("sym_bits_hold", 32'(bus.SYM_BITS), 32'(cur_bits));
      check("sym_len_hold", 32'(bus.SYM_LEN), 32'(cur_len));
    end
  end

  // ---------------- directed stimulus ----------------
  int v0, e0, w0;

  initial begin
    bus.SIG = 1'b0;
    rstn    = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rstn = 1'b1;
    check("rst_sym_valid", 32'(bus.SYM_VALID), 0);
    check("rst_error", 32'(bus.ERROR), 0);
    check("rst_word_gap", 32'(bus.WORD_GAP), 0);
    check("rst_active", 32'(bus.ACTIVE), 0);
    check("rst_sym_len", 32'(bus.SYM_LEN), 0);
    check("rst_sym_bits", 32'(bus.SYM_BITS), 0);

    // "A": dot, dash, then long low
    v0 = n_valid; w0 = n_word;
    seg(1, 8); seg(0, 8);
    check("a_active_space", 32'(bus.ACTIVE), 1);
    seg(1, 24);
    check("a_active_mark", 32'(bus.ACTIVE), 1);
    seg(0, 60);
    check("a_valid_count", n_valid - v0, 1);
    check("a_word_count", n_word - w0, 1);
    check("a_len", 32'(bus.SYM_LEN), 2);
    check("a_bits", 32'(bus.SYM_BITS), 32'h02);
    check("a_word_after_valid", last_word_cyc - last_valid_cyc, 24);
    check("a_idle_active", 32'(bus.ACTIVE), 0);

    // overflow: seven dots leave the previous symbol in place
    v0 = n_valid; e0 = n_error;
    for (int i = 0; i < 7; i++) begin
      seg(1, 8);
      seg(0, (i == 6) ? 60 : 8);
    end
    check("ovf_error_count", n_error - e0, 1);
    check("ovf_no_valid", n_valid - v0, 0);
    check("ovf_len_kept", 32'(bus.SYM_LEN), 2);
    check("ovf_bits_kept", 32'(bus.SYM_BITS), 32'h02);

    // six dots: maximum-length symbol
    for (int i = 0; i < 6; i++) begin
      seg(1, 8);
      seg(0, (i == 5) ? 60 : 8);
    end
    check("six_len", 32'(bus.SYM_LEN), 6);
    check("six_bits", 32'(bus.SYM_BITS), 0);

    // rounding: 11 -> dot, 19 -> dot, 20 -> dash
    seg(1, 11); seg(0, 8); seg(1, 19); seg(0, 8); seg(1, 20); seg(0, 30);
    check("round_len", 32'(bus.SYM_LEN), 3);
    check("round_bits", 32'(bus.SYM_BITS), 32'h04);
    check("gap_wait_inactive", 32'(bus.ACTIVE), 0);

    // glitch of 3 between two dots
    seg(1, 8); seg(0, 8); seg(1, 3); seg(0, 8); seg(1, 8); seg(0, 60);
    check("glitch_len", 32'(bus.SYM_LEN), 2);
    check("glitch_bits", 32'(bus.SYM_BITS), 0);

    // reset in the middle of a symbol
    v0 = n_valid;
    seg(1, 8); seg(0, 8); seg(1, 8); seg(0, 1);
    do_reset();
    check("mid_rst_len", 32'(bus.SYM_LEN), 0);
    check("mid_rst_bits", 32'(bus.SYM_BITS), 0);
    check("mid_rst_active", 32'(bus.ACTIVE), 0);
    check("mid_rst_valid", 32'(bus.SYM_VALID), 0);
    seg(0, 4);
    check("mid_rst_no_pulse", n_valid - v0, 0);
    seg(1, 24); seg(0, 8); seg(1, 8); seg(0, 60);
    check("post_rst_len", 32'(bus.SYM_LEN), 2);
    check("post_rst_bits", 32'(bus.SYM_BITS), 32'h01);

    // rising edge lands exactly when the char-gap threshold is hit
    v0 = n_valid; w0 = n_word;
    seg(1, 8); seg(0, 17); seg(1, 24); seg(0, 60);
    check("collide_valid_count", n_valid - v0, 2);
    check("collide_word_count", n_word - w0, 1);
    check("collide_len", 32'(bus.SYM_LEN), 1);
    check("collide_bits", 32'(bus.SYM_BITS), 32'h01);

    // "N E"
    v0 = n_valid; w0 = n_word;
    seg(1, 24); seg(0, 8); seg(1, 8); seg(0, 56);
    check("n_len", 32'(bus.SYM_LEN), 2);
    check("n_bits", 32'(bus.SYM_BITS), 32'h01);
    check("n_word_count", n_word - w0, 1);
    seg(1, 8); seg(0, 60);
    check("ne_valid_count", n_valid - v0, 2);
    check("ne_word_count", n_word - w0, 2);
    check("e_len", 32'(bus.SYM_LEN), 1);
    check("e_bits", 32'(bus.SYM_BITS), 0);

    repeat (5) @(posedge clk);
    #1;
    check("queue_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
